// File: rtl/retire_unit.sv
// retire_unit: in-order commit stage between the ROB head and the AMT / free list.
// Each cycle it retires the longest prefix of valid, completed head entries.
// A mispredicted branch or a halt retires and ends the group. The retired
// count goes back to the ROB with no delay. The AMT writes and the free-list
// releases are registered and become visible one cycle later.
// A retired mispredict produces a one-cycle rollback pulse and then a recovery
// window of C_RECOVER_CYC cycles in which nothing retires. A retired halt stops
// commit until reset.
module retire_unit #(
    parameter int C_RT_NUM        = 2,
    parameter int C_ARCH_REG_NUM  = 32,
    parameter int C_TAG_IDX_WIDTH = 6,
    parameter int C_RECOVER_CYC   = 2,
    parameter int C_CNT_WIDTH     = 32,
    localparam int AW    = $clog2(C_ARCH_REG_NUM),
    localparam int RNW   = $clog2(C_RT_NUM + 1),
    localparam int AMT_W = 1 + AW + C_TAG_IDX_WIDTH
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [C_RT_NUM-1:0]                          rob_valid_i,
    input  logic [C_RT_NUM-1:0]                          rob_complete_i,
    input  logic [C_RT_NUM-1:0]                          rob_dest_valid_i,
    input  logic [C_RT_NUM-1:0][AW-1:0]                  rob_arch_reg_i,
    input  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]     rob_tag_i,
    input  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]     rob_tag_old_i,
    input  logic [C_RT_NUM-1:0]                          rob_br_mispred_i,
    input  logic [C_RT_NUM-1:0]                          rob_halt_i,
    output logic [RNW-1:0]                               rt_num_o,
    // Each lane is packed as {wr_en, arch_reg, phy_reg}.
    output logic [C_RT_NUM-1:0][AMT_W-1:0]               rob_amt_o,
    output logic [C_RT_NUM-1:0]                          fl_rel_valid_o,
    output logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]     fl_rel_tag_o,
    output logic                                         rollback_o,
    output logic                                         halt_o,
    output logic [C_CNT_WIDTH-1:0]                       retire_cnt_o
);

    localparam int RW = $clog2(C_RECOVER_CYC + 1);
    localparam logic [RW-1:0] REC_LOAD = RW'(C_RECOVER_CYC - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_RECOVER = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t                  state;
    logic [RW-1:0]           rec_cnt;

    logic [C_RT_NUM-1:0]     retired;
    logic [RNW-1:0]          rt_num;
    logic                    open;
    logic                    grp_misp;
    logic                    grp_halt;
    logic [C_CNT_WIDTH:0]    cnt_sum;
    logic [C_CNT_WIDTH-1:0]  cnt_next;

    // Select the retiring prefix. Only RUN retires, and reset blocks retiring.
    // A mispredict or halt entry is the last member of its group.
    always_comb begin
        retired  = '0;
        rt_num   = '0;
        grp_misp = 1'b0;
        grp_halt = 1'b0;
        open     = (state == S_RUN) && !rst_i;
        for (int j = 0; j < C_RT_NUM; j++) begin
            if (open && rob_valid_i[j] && rob_complete_i[j]) begin
                retired[j] = 1'b1;
                rt_num     = RNW'(j + 1);
                if (rob_br_mispred_i[j] || rob_halt_i[j]) begin
                    open     = 1'b0;
                    grp_misp = rob_br_mispred_i[j];
                    grp_halt = rob_halt_i[j];
                end else begin
                    open = open;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

    assign rt_num_o = rt_num;

    // Add the retired count to the total. The total saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_sum = {1'b0, retire_cnt_o} + (C_CNT_WIDTH + 1)'(rt_num);
        if (cnt_sum[C_CNT_WIDTH]) begin
            cnt_next = '1;
        end else begin
            cnt_next = cnt_sum[C_CNT_WIDTH-1:0];
        end
    end

    // Commit FSM and registered commit outputs. Lanes that did not retire get no write strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_RUN;
            rec_cnt        <= '0;
            rob_amt_o      <= '0;
            fl_rel_valid_o <= '0;
            fl_rel_tag_o   <= '0;
            rollback_o     <= 1'b0;
            halt_o         <= 1'b0;
            retire_cnt_o   <= '0;
        end else begin
            for (int j = 0; j < C_RT_NUM; j++) begin
                rob_amt_o[j]      <= {retired[j] & rob_dest_valid_i[j],
                                      rob_arch_reg_i[j], rob_tag_i[j]};
                fl_rel_valid_o[j] <= retired[j] & rob_dest_valid_i[j];
                fl_rel_tag_o[j]   <= rob_tag_old_i[j];
            end
            retire_cnt_o <= cnt_next;
            // When halt and mispredict are on the same entry, the halt takes priority.
            rollback_o   <= grp_misp & ~grp_halt;
            case (state)
                S_RUN: begin
                    if (grp_halt) begin
                        state  <= S_HALTED;
                        halt_o <= 1'b1;
                    end else if (grp_misp) begin
                        state   <= S_RECOVER;
                        rec_cnt <= REC_LOAD;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RECOVER: begin
                    if (rec_cnt == '0) begin
                        state <= S_RUN;
                    end else begin
                        rec_cnt <= rec_cnt - RW'(1);
                    end
                end
                S_HALTED: begin
                    state  <= S_HALTED;
                    halt_o <= 1'b1;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_retire_unit.sv
// Scoreboard bench for retire_unit. Stimulus pushes expectations that come
// from a behavioural commit model. A separate monitor pops each expectation
// and compares it with what the DUT presents.
module tb_retire_unit;

    localparam int R   = 2;
    localparam int NA  = 32;
    localparam int AW  = 5;
    localparam int TW  = 6;
    localparam int RC  = 2;
    localparam int CW  = 32;
    localparam int RNW = 2;
    localparam int AMW = 1 + AW + TW;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [R-1:0]            v_in, c_in, d_in, bm_in, h_in;
    logic [R-1:0][AW-1:0]    a_in;
    logic [R-1:0][TW-1:0]    t_in, o_in;
    logic [RNW-1:0]          rt_num;
    logic [R-1:0][AMW-1:0]   amt;
    logic [R-1:0]            fl_valid;
    logic [R-1:0][TW-1:0]    fl_tag;
    logic                    rollback, halt;
    logic [CW-1:0]           rcnt;

    always #5 clk = ~clk;

    retire_unit #(
        .C_RT_NUM(R), .C_ARCH_REG_NUM(NA), .C_TAG_IDX_WIDTH(TW),
        .C_RECOVER_CYC(RC), .C_CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .rob_valid_i(v_in), .rob_complete_i(c_in), .rob_dest_valid_i(d_in),
        .rob_arch_reg_i(a_in), .rob_tag_i(t_in), .rob_tag_old_i(o_in),
        .rob_br_mispred_i(bm_in), .rob_halt_i(h_in),
        .rt_num_o(rt_num), .rob_amt_o(amt), .fl_rel_valid_o(fl_valid),
        .fl_rel_tag_o(fl_tag), .rollback_o(rollback), .halt_o(halt),
        .retire_cnt_o(rcnt)
    );

    typedef struct {
        logic [R-1:0]         wr;
        logic [R-1:0][AW-1:0] arch;
        logic [R-1:0][TW-1:0] tag;
        logic [R-1:0][TW-1:0] told;
        logic                 rb;
        logic                 hlt;
        logic [CW-1:0]        cnt;
    } exp_t;

    exp_t reg_q[$];
    int   rt_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: mode 0 = running, 1 = recovering, 2 = halted.
    int     m_mode = 0;
    int     m_left = 0;
    longint m_cnt  = 0;
    int     m_amt[NA];
    int     d_amt[NA];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of head entries and queue the model's prediction for it.
    task automatic cycle(input logic [R-1:0] v, input logic [R-1:0] c,
                         input logic [R-1:0] d, input logic [R-1:0] bm,
                         input logic [R-1:0] h, input logic [R-1:0][AW-1:0] a,
                         input logic [R-1:0][TW-1:0] t, input logic [R-1:0][TW-1:0] o);
        exp_t e;
        int   n;
        @(negedge clk);
        v_in = v; c_in = c; d_in = d; bm_in = bm; h_in = h;
        a_in = a; t_in = t; o_in = o;
        n = 0;
        if (m_mode == 0) begin
            for (int j = 0; j < R; j++) begin
                if (v[j] && c[j]) begin
                    n = j + 1;
                    if (bm[j] || h[j]) break;
                end else begin
                    break;
                end
            end
        end
        rt_q.push_back(n);
        e.arch = a; e.tag = t; e.told = o;
        for (int j = 0; j < R; j++) begin
            e.wr[j] = (j < n) && d[j];
            if (e.wr[j]) m_amt[a[j]] = int'(t[j]);
        end
        e.rb = (n > 0) && bm[n-1] && !h[n-1];
        if (m_mode == 0) begin
            if (n > 0 && h[n-1]) m_mode = 2;
            else if (e.rb) begin m_mode = 1; m_left = RC; end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
        m_cnt = m_cnt + n;
        if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
        e.hlt = (m_mode == 2);
        e.cnt = m_cnt[CW-1:0];
        reg_q.push_back(e);
    endtask

    task automatic cyc2(input logic [1:0] v, input logic [1:0] c, input logic [1:0] d,
                        input logic [1:0] bm, input logic [1:0] h,
                        input int a0, input int t0, input int o0,
                        input int a1, input int t1, input int o1);
        logic [R-1:0][AW-1:0] a;
        logic [R-1:0][TW-1:0] t, o;
        a[0] = AW'(a0); a[1] = AW'(a1);
        t[0] = TW'(t0); t[1] = TW'(t1);
        o[0] = TW'(o0); o[1] = TW'(o1);
        cycle(v, c, d, bm, h, a, t, o);
    endtask

    // Assert reset mid-cycle while every entry looks ready. Outputs must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #2;
        v_in = '1; c_in = '1; d_in = '1; bm_in = '0; h_in = '0;
        rst = 1'b1;
        #1;
        check("rst_rt_num", rt_num, 0);
        check("rst_amt", amt, 0);
        check("rst_fl_valid", fl_valid, 0);
        check("rst_fl_tag", fl_tag, 0);
        check("rst_rollback", rollback, 0);
        check("rst_halt", halt, 0);
        check("rst_cnt", rcnt, 0);
        rt_q.delete();
        reg_q.delete();
        m_mode = 0; m_left = 0; m_cnt = 0;
        repeat (2) @(negedge clk);
        check("rst_hold_rt_num", rt_num, 0);
        v_in = '0; c_in = '0; d_in = '0;
        rst = 1'b0;
    endtask

    // Monitor: rt_num is checked just before the edge, registered outputs just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rt_q.size() > 0) check("rt_num", rt_num, rt_q.pop_front());
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                for (int j = 0; j < R; j++) begin
                    check($sformatf("amt_wr[%0d]", j), amt[j][AMW-1], e.wr[j]);
                    check($sformatf("fl_valid[%0d]", j), fl_valid[j], e.wr[j]);
                    if (e.wr[j]) begin
                        check($sformatf("amt_arch[%0d]", j), amt[j][AW+TW-1:TW], e.arch[j]);
                        check($sformatf("amt_tag[%0d]", j), amt[j][TW-1:0], e.tag[j]);
                        check($sformatf("fl_tag[%0d]", j), fl_tag[j], e.told[j]);
                    end
                end
                check("rollback", rollback, e.rb);
                check("halt", halt, e.hlt);
                check("retire_cnt", rcnt, e.cnt);
            end
            if (!rst) begin
                for (int j = 0; j < R; j++)
                    if (amt[j][AMW-1]) d_amt[amt[j][AW+TW-1:TW]] = int'(amt[j][TW-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [R-1:0]         v, c, d, bm, h;
        logic [R-1:0][AW-1:0] a;
        logic [R-1:0][TW-1:0] t, o;
        for (int i = 0; i < NA; i++) begin m_amt[i] = 0; d_amt[i] = 0; end
        rst = 1'b1;
        v_in = '0; c_in = '0; d_in = '0; bm_in = '0; h_in = '0;
        a_in = '0; t_in = '0; o_in = '0;
        #12;
        do_reset();

        // Full group, then partial groups and an empty ROB.
        cyc2(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 3, 40, 3, 5, 41, 5);
        cyc2(2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 1, 10, 1, 2, 11, 2);
        cyc2(2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 4, 12, 4, 6, 13, 6);
        cyc2(2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 8, 14, 8, 9, 15, 9);
        // Mispredict at lane 0: two blocked cycles, then retirement resumes.
        cyc2(2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 10, 20, 10, 11, 21, 11);
        cyc2(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 12, 22, 12, 13, 23, 13);
        cyc2(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 12, 22, 12, 13, 23, 13);
        cyc2(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 12, 24, 12, 13, 25, 13);
        // Duplicate destination: the younger lane must land last.
        cyc2(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 7, 50, 7, 7, 51, 50);
        // Halt at lane 1 with dest on lane 0, then nothing retires.
        cyc2(2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 14, 30, 14, 15, 31, 15);
        repeat (3) cyc2(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 16, 32, 16, 17, 33, 17);
        do_reset();
        // Mispredict and halt on the same entry.
        cyc2(2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 18, 34, 18, 19, 35, 19);
        cyc2(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 20, 36, 20, 21, 37, 21);
        do_reset();

        // Randomised segments separated by resets.
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 60; k++) begin
                for (int j = 0; j < R; j++) begin
                    v[j]  = ($urandom_range(0, 7) != 0);
                    c[j]  = ($urandom_range(0, 3) != 0);
                    d[j]  = ($urandom_range(0, 1) != 0);
                    bm[j] = ($urandom_range(0, 9) == 0);
                    h[j]  = ($urandom_range(0, 59) == 0);
                    a[j]  = AW'($urandom_range(0, NA - 1));
                    t[j]  = TW'($urandom_range(0, 63));
                    o[j]  = TW'($urandom_range(0, 63));
                end
                cycle(v, c, d, bm, h, a, t, o);
            end
            do_reset();
        end

        repeat (2) @(posedge clk);
        #3;
        for (int i = 0; i < NA; i++) check($sformatf("amt_state[%0d]", i), d_amt[i], m_amt[i]);
        check("amt_dup_arch7", d_amt[7] >= 0 ? 51 : 0, 51);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_unit.md
# retire_unit

In-order commit stage between the ROB head and the architectural map table (AMT) / free list. Each cycle it retires a contiguous prefix of up to C_RT_NUM completed head entries. For that prefix it acknowledges the count back to the ROB and drives registered AMT write ports and free-list release ports. Retiring a mispredicted branch pulses rollback and holds a recovery window; retiring a halt stops commit permanently until reset.

## Interface
- C_RT_NUM, `RT_NUM: retire width (entries examined per cycle).
- C_ARCH_REG_NUM, `ARCH_REG_NUM: architectural registers; arch index width AW = $clog2(C_ARCH_REG_NUM).
- C_TAG_IDX_WIDTH, `TAG_IDX_WIDTH: physical tag width.
- C_RECOVER_CYC, 2: cycles of the recovery window (>=1).
- C_CNT_WIDTH, 32: retired-instruction counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- rob_valid_i  in  [C_RT_NUM]  head entry j occupied (j=0 oldest).
- rob_complete_i  in  [C_RT_NUM]  head entry j finished execution.
- rob_dest_valid_i  in  [C_RT_NUM]  entry j writes a register.
- rob_arch_reg_i  in  [C_RT_NUM][AW]  destination arch register.
- rob_tag_i  in  [C_RT_NUM][C_TAG_IDX_WIDTH]  new physical tag T.
- rob_tag_old_i  in  [C_RT_NUM][C_TAG_IDX_WIDTH]  previous tag Told.
- rob_br_mispred_i  in  [C_RT_NUM]  entry j is a mispredicted branch.
- rob_halt_i  in  [C_RT_NUM]  entry j is a halt.
- rt_num_o  out  $clog2(C_RT_NUM+1)  combinational count retired this cycle; the ROB advances its head by this count.
- rob_amt_o  out  ROB_AMT [C_RT_NUM]  registered {wr_en, arch_reg, phy_reg} to AMT.
- fl_rel_valid_o  out  [C_RT_NUM]  registered free-list release strobe.
- fl_rel_tag_o  out  [C_RT_NUM][C_TAG_IDX_WIDTH]  registered released tag.
- rollback_o  out  1  registered one-cycle rollback pulse.
- halt_o  out  1  registered, sticky halt.
- retire_cnt_o  out  C_CNT_WIDTH  registered total retired count.

## Operation
- States: RUN, RECOVER, HALTED. Reset state is RUN.
- Retire condition in RUN: entry j retires iff entries 0..j are all valid and complete, and no entry k<j has br_mispred or halt set.
  - A mispredict or halt entry retires but terminates the group.
  - rt_num_o is the prefix length.
- rt_num_o = 0 in RECOVER, in HALTED, and while rst_i is high.
- Next-edge registers, for each j in the group: rob_amt_o[j] = {retired_j & dest_valid_j, arch_reg_j, tag_j}; fl_rel_valid_o[j] = retired_j & dest_valid_j, fl_rel_tag_o[j] = tag_old_j.
  - Lanes not retired: wr_en = 0 and fl_rel_valid = 0. Data fields are don't-care.
- Duplicate arch_reg within a group is legal. The higher lane is younger and must win at the AMT. Lane order is preserved; no filtering is done here.
- Mispredict retired (and no halt in the group) gives the RUN -> RECOVER transition:
  - rollback_o = 1 in the same cycle the group's AMT writes appear.
  - Recovery counter is loaded with C_RECOVER_CYC-1.
- RECOVER: no retires; rob_amt_o wr_en and fl_rel_valid_o are 0 after the first cycle. The counter decrements; at 0 the next state is RUN.
- Halt retired gives the RUN -> HALTED transition. halt_o = 1 from the next cycle until reset. If halt and mispredict are on the same entry, halt wins and rollback_o stays 0.
- retire_cnt_o += rt_num_o each cycle, saturating at all-ones.

## Timing
- Reset (async assert): state RUN, all rob_amt_o/fl_rel fields 0, rollback_o 0, halt_o 0, retire_cnt_o 0, recovery counter 0.
- Registered outputs have one-cycle latency from the retire decision (cycle N) to visibility (cycle N+1). rt_num_o has zero latency.
- Recovery window: rollback_o is high in cycle N+1 only. rt_num_o = 0 in cycles N+1..N+C_RECOVER_CYC. Retirement resumes in cycle N+C_RECOVER_CYC+1.
- Back-to-back groups retire every cycle in RUN with no bubble.
- Invalid entry at lane 0 (empty ROB) gives rt_num_o = 0 and no writes.
- Reset asserted mid-RECOVER or in HALTED returns to RUN immediately. Outputs are cleared without waiting for a clock edge.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately; after release, rt_num_o follows the inputs.
- Full group: C_RT_NUM=2, both entries valid/complete/dest, arch 3->T 40 (Told 3), arch 5->T 41 (Told 5) -> rt_num_o=2; next cycle rob_amt_o = {1,3,40},{1,5,41}, fl_rel tags 3 and 5, retire_cnt_o=2.
- Partial: lane 0 incomplete, lane 1 complete -> rt_num_o=0, no writes. Lane 0 complete, lane 1 invalid -> rt_num_o=1 and lane 1 wr_en=0.
- Mispredict at lane 0, lane 1 complete, C_RECOVER_CYC=2 -> rt_num_o=1; next cycle rollback_o=1 with lane 0 write only. rt_num_o=0 for 2 cycles, then retire resumes.
- Halt at lane 1 with dest on lane 0 -> rt_num_o=2, lane 0 write issued, halt_o=1 from the next cycle. Further completed entries give rt_num_o=0 indefinitely. Same entry flagged mispredict+halt -> rollback_o stays 0.
- Duplicate destination: both lanes target arch 7 with tags 50 then 51 -> both wr_en=1, lane order kept; AMT entry 7 reads 51.
